source_id_queue: RTL and testbench

//   Ready/valid FIFO controller for TileLink source IDs; owns pointers, full/empty and handshake.

---
 rtl/source_id_queue_pkg.sv | 20 ++
 rtl/source_id_ram.sv | 24 ++
 rtl/source_id_queue.sv | 102 ++++++++++
 tb/tb_source_id_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/source_id_queue_pkg.sv
// rtl/source_id_queue_pkg.sv - shared types, default geometry and pointer wrap helper for source_id_queue
package source_id_queue_pkg;

    localparam int SRC_W     = 7;
    localparam int SRC_DEPTH = 2;

    typedef logic [SRC_W-1:0] src_id_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    // Explicit wrap so non-power-of-two depths never rely on binary overflow.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/source_id_ram.sv
// rtl/source_id_ram.sv - DEPTH x DATA_W storage, synchronous write port, asynchronous read port
module source_id_ram #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 7
) (
    input  logic                     clock,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/source_id_queue.sv
// rtl/source_id_queue.sv - ready/valid source-ID FIFO controller over source_id_ram
// Optional flow-through-when-empty behaviour enabled by macro SOURCE_ID_QUEUE_FLOW_EN.
module source_id_queue
    import source_id_queue_pkg::*;
#(
    parameter int DEPTH  = SRC_DEPTH,
    parameter int DATA_W = SRC_W
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       io_enq_ready,
    input  logic                       io_enq_valid,
    input  logic [DATA_W-1:0]          io_enq_bits,
    input  logic                       io_deq_ready,
    output logic                       io_deq_valid,
    output logic [DATA_W-1:0]          io_deq_bits,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic              maybe_full_q, maybe_full_d;
    logic              ptr_match;
    logic              do_enq, do_deq;
    logic [DATA_W-1:0] ram_rd_data;
    occ_state_e        occ;

    always_comb begin
        ptr_match = (wptr_q == rptr_q);
        if (ptr_match && !maybe_full_q) begin
            occ = OCC_EMPTY;
        end else if (ptr_match) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end

        io_enq_ready = (occ != OCC_FULL);
        io_deq_valid = (occ != OCC_EMPTY);
        io_deq_bits  = ram_rd_data;
`ifdef SOURCE_ID_QUEUE_FLOW_EN
        if (occ == OCC_EMPTY) begin
            io_deq_valid = io_enq_valid;
            io_deq_bits  = io_enq_bits;
        end
`endif
        do_enq = io_enq_valid & io_enq_ready;
        do_deq = io_deq_valid & io_deq_ready;
`ifdef SOURCE_ID_QUEUE_FLOW_EN
        // Entry passes straight through; storage and pointers stay untouched.
        if (occ == OCC_EMPTY && io_deq_ready) begin
            do_enq = 1'b0;
            do_deq = 1'b0;
        end
`endif

        wptr_d       = do_enq ? PTR_W'(ptr_inc(32'(wptr_q), DEPTH)) : wptr_q;
        rptr_d       = do_deq ? PTR_W'(ptr_inc(32'(rptr_q), DEPTH)) : rptr_q;
        maybe_full_d = (do_enq != do_deq) ? do_enq : maybe_full_q;

        unique case (occ)
            OCC_EMPTY: io_count = '0;
            OCC_FULL:  io_count = CNT_W'(DEPTH);
            default: begin
                if (wptr_q >= rptr_q) begin
                    io_count = CNT_W'(wptr_q) - CNT_W'(rptr_q);
                end else begin
                    io_count = CNT_W'(wptr_q) + CNT_W'(DEPTH) - CNT_W'(rptr_q);
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    // Writes in the reset cycle are dropped along with the pointers.
    source_id_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (do_enq & ~reset),
        .wr_addr_i (wptr_q),
        .wr_data_i (io_enq_bits),
        .rd_addr_i (rptr_q),
        .rd_data_o (ram_rd_data)
    );

endmodule

// File: tb/tb_source_id_queue.sv
// tb/tb_source_id_queue.sv - scoreboard bench for source_id_queue with directed and random traffic
module tb_source_id_queue;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 7;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              io_enq_ready;
    logic              io_enq_valid;
    logic [DATA_W-1:0] io_enq_bits;
    logic              io_deq_ready;
    logic              io_deq_valid;
    logic [DATA_W-1:0] io_deq_bits;
    logic [CNT_W-1:0]  io_count;

    source_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_ready (io_enq_ready),
        .io_enq_valid (io_enq_valid),
        .io_enq_bits  (io_enq_bits),
        .io_deq_ready (io_deq_ready),
        .io_deq_valid (io_deq_valid),
        .io_deq_bits  (io_deq_bits),
        .io_count     (io_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [DATA_W-1:0] model_q[$];
    int                sz;
    bit                exp_valid, flow_case;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs with the reference queue, then applies this cycle's handshakes.
    always @(negedge clock) begin
        if (mon_en) begin
            sz        = model_q.size();
            exp_valid = (sz > 0);
            flow_case = 1'b0;
`ifdef SOURCE_ID_QUEUE_FLOW_EN
            if (sz == 0) begin
                exp_valid = io_enq_valid;
                flow_case = io_enq_valid && io_deq_ready;
            end
`endif
            check("enq_ready", 32'(io_enq_ready), 32'(sz < DEPTH));
            check("deq_valid", 32'(io_deq_valid), 32'(exp_valid));
            check("count", 32'(io_count), 32'(sz));
            if (reset) begin
                model_q.delete();
            end else if (flow_case) begin
                check("flow_bits", 32'(io_deq_bits), 32'(io_enq_bits));
            end else begin
                if (io_deq_ready && sz > 0) begin
                    check("deq_bits", 32'(io_deq_bits), 32'(model_q[0]));
                    void'(model_q.pop_front());
                end
                if (io_enq_valid && sz < DEPTH) begin
                    model_q.push_back(io_enq_bits);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic ev, input logic [DATA_W-1:0] b, input logic dr);
        io_enq_valid = ev;
        io_enq_bits  = b;
        io_deq_ready = dr;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        cyc(1);
        mon_en = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(3);

        // Fill
        drive(1'b1, 7'h15, 1'b0);
        cyc(1);
        check("fill_count1", 32'(io_count), 32'd1);
        drive(1'b1, 7'h2A, 1'b0);
        cyc(1);
        check("fill_count2", 32'(io_count), 32'd2);
        check("fill_enq_ready", 32'(io_enq_ready), 32'd0);
        check("fill_head", 32'(io_deq_bits), 32'h15);

        // Full: attempted write is refused, then drain
        drive(1'b1, 7'h7F, 1'b0);
        cyc(2);
        drive(1'b0, '0, 1'b1);
        cyc(2);
        check("drain_empty", 32'(io_deq_valid), 32'd0);
        drive(1'b0, '0, 1'b0);

        // Concurrent enq+deq at count=1 across pointer wrap
        drive(1'b1, 7'h01, 1'b0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'(7'h40 + i), 1'b1);
            cyc(1);
            check("conc_count", 32'(io_count), 32'd1);
        end
        drive(1'b1, 7'h11, 1'b0);
        cyc(1);

        // Mid-stream reset while full with enq_valid high
        reset = 1'b1;
        drive(1'b1, 7'h22, 1'b0);
        cyc(1);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0);
        check("rst_count", 32'(io_count), 32'd0);
        check("rst_deq_valid", 32'(io_deq_valid), 32'd0);
        check("rst_enq_ready", 32'(io_enq_ready), 32'd1);

        // Enqueue into empty queue with consumer ready
        drive(1'b1, 7'h33, 1'b1);
        #1;
`ifdef SOURCE_ID_QUEUE_FLOW_EN
        check("flow_same_valid", 32'(io_deq_valid), 32'd1);
        check("flow_same_bits", 32'(io_deq_bits), 32'h33);
        cyc(1);
        drive(1'b0, '0, 1'b1);
        check("flow_count", 32'(io_count), 32'd0);
`else
        check("noflow_same_valid", 32'(io_deq_valid), 32'd0);
        cyc(1);
        drive(1'b0, '0, 1'b1);
        check("noflow_next_valid", 32'(io_deq_valid), 32'd1);
        check("noflow_next_bits", 32'(io_deq_bits), 32'h33);
`endif
        cyc(1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 2) != 0));
            cyc(1);
        end
        reset = 1'b0;
        drive(1'b0, '0, 1'b0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
